// File: rtl/sdram_dev_responder.sv
// sdram_dev_responder: SDRAM device-side model that decodes controller commands, stores write
// bursts in an on-chip array, returns read bursts after CAS latency and flags protocol violations.
module sdram_dev_responder #(
    parameter int DW       = 16,
    parameter int AW       = 13,
    parameter int COL_BITS = 9,
    parameter int ROW_USE  = 2
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic [3:0]    sdram_cmd,
    input  logic [1:0]    sdram_ba,
    input  logic [AW-1:0] sdram_addr,
    input  logic [DW-1:0] sdram_dq_in,
    output logic [DW-1:0] sdram_dq_out,
    output logic          sdram_dq_oe,
    output logic          mode_ok,
    output logic [2:0]    cas_lat,
    output logic [15:0]   refresh_cnt,
    output logic          proto_err,
    output logic [2:0]    err_code
);
    localparam int IW = 2 + ROW_USE + COL_BITS;
    localparam logic [2:0] OP_LMR = 3'd0, OP_AREF = 3'd1, OP_PRE = 3'd2, OP_ACT = 3'd3;
    localparam logic [2:0] OP_WR = 3'd4, OP_RD = 3'd5, OP_BT = 3'd6, OP_NOP = 3'd7;

    logic [DW-1:0]       r_mem [2**IW];
    logic [DW-1:0]       r_mem_q;
    logic [ROW_USE-1:0]  r_row [4];
    logic [3:0]          r_open;
    logic                r_mode_ok;
    logic [2:0]          r_cl, r_bl, r_ecode;
    logic [15:0]         r_ref;
    logic                r_perr;
    logic                r_bst_act, r_bst_wr;
    logic [1:0]          r_bst_ba;
    logic [ROW_USE-1:0]  r_bst_row;
    logic [COL_BITS-1:0] r_bst_col;
    logic [2:0]          r_bst_left;
    logic                r_rd_cl3, r_iss, r_iss_cl3, r_p1_v, r_dq_oe;
    logic [DW-1:0]       r_p1_d, r_dq_out;

    logic [2:0]          w_op, w_new_cl, w_err, w_go_left;
    logic                w_any_open, w_bank_open, w_rw, w_start, w_page, w_kill, w_cont, w_go;
    logic                w_go_wr, w_we, w_re, w_cl3, w_flush, w_direct;
    logic [1:0]          w_go_ba;
    logic [ROW_USE-1:0]  w_go_row;
    logic [COL_BITS-1:0] w_mask, w_go_col, w_col_nxt;
    logic [IW-1:0]       w_idx;

    assign w_op        = sdram_cmd[3] ? OP_NOP : sdram_cmd[2:0];
    assign w_new_cl    = sdram_addr[6:4];
    assign w_any_open  = |r_open;
    assign w_bank_open = r_open[sdram_ba];
    assign w_rw        = (w_op == OP_RD) || (w_op == OP_WR);
    assign w_err = (w_op == OP_LMR && w_any_open) ? 3'd5 :
                   (w_op == OP_LMR && w_new_cl != 3'd2 && w_new_cl != 3'd3) ? 3'd6 :
                   ((w_rw || w_op == OP_ACT) && !r_mode_ok) ? 3'd1 :
                   (w_op == OP_ACT && w_bank_open) ? 3'd2 :
                   (w_op == OP_AREF && w_any_open) ? 3'd3 :
                   (w_rw && !w_bank_open) ? 3'd4 : 3'd0;

    // The burst engine picks one word per cycle: a freshly accepted RD/WR wins over a running burst.
    assign w_start   = w_rw && r_mode_ok && w_bank_open;
    assign w_page    = r_bl == 3'b111;
    assign w_mask    = w_page ? '1 : r_bl[2] ? '0 : COL_BITS'((32'd1 << r_bl[1:0]) - 32'd1);
    assign w_kill    = (w_op == OP_BT) || (w_op == OP_PRE && (sdram_addr[10] || sdram_ba == r_bst_ba));
    assign w_cont    = r_bst_act && !w_kill && !w_start;
    assign w_go      = w_start || w_cont;
    assign w_go_wr   = w_start ? (w_op == OP_WR) : r_bst_wr;
    assign w_go_ba   = w_start ? sdram_ba : r_bst_ba;
    assign w_go_row  = w_start ? r_row[sdram_ba] : r_bst_row;
    assign w_go_col  = w_start ? sdram_addr[COL_BITS-1:0] : r_bst_col;
    assign w_go_left = w_start ? w_mask[2:0] : r_bst_left - 3'd1;
    assign w_col_nxt = (w_go_col & ~w_mask) | ((w_go_col + 1'b1) & w_mask);
    assign w_idx     = {w_go_ba, w_go_row, w_go_col};
    assign w_we      = w_go && w_go_wr;
    assign w_re      = w_go && !w_go_wr;
    assign w_cl3     = w_start ? (r_cl == 3'd3) : r_rd_cl3;
    assign w_flush   = w_start && w_go_wr;
    assign w_direct  = r_iss && !r_iss_cl3;

    always_ff @(posedge sys_clk) begin
        if (w_we) r_mem[w_idx] <= sdram_dq_in;
        r_mem_q <= r_mem[w_idx];
        if (w_op == OP_ACT && w_err == 3'd0) r_row[sdram_ba] <= sdram_addr[ROW_USE-1:0];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_open     <= '0;
            r_mode_ok  <= 1'b0;
            r_cl       <= 3'd3;
            r_bl       <= '0;
            r_ref      <= '0;
            r_perr     <= 1'b0;
            r_ecode    <= '0;
            r_bst_act  <= 1'b0;
            r_bst_wr   <= 1'b0;
            r_bst_ba   <= '0;
            r_bst_row  <= '0;
            r_bst_col  <= '0;
            r_bst_left <= '0;
            r_rd_cl3   <= 1'b1;
            r_iss      <= 1'b0;
            r_iss_cl3  <= 1'b1;
            r_p1_v     <= 1'b0;
            r_p1_d     <= '0;
            r_dq_oe    <= 1'b0;
            r_dq_out   <= '0;
        end else begin
            r_perr <= w_err != 3'd0;
            if (w_err != 3'd0) r_ecode <= w_err;
            if (w_op == OP_LMR && !w_any_open) begin
                r_mode_ok <= 1'b1;
                r_bl      <= sdram_addr[2:0];
                if (w_err == 3'd0) r_cl <= w_new_cl;
            end
            if (w_op == OP_ACT && w_err == 3'd0) r_open[sdram_ba] <= 1'b1;
            if (w_op == OP_PRE) r_open <= sdram_addr[10] ? 4'b0 : r_open & ~(4'b1 << sdram_ba);
            if (w_op == OP_AREF && w_err == 3'd0) r_ref <= r_ref + 16'd1;
            r_bst_act  <= w_go && (w_page || w_go_left != 3'd0);
            r_bst_wr   <= w_go_wr;
            r_bst_ba   <= w_go_ba;
            r_bst_row  <= w_go_row;
            r_bst_col  <= w_col_nxt;
            r_bst_left <= w_go_left;
            r_rd_cl3   <= w_cl3;
            r_iss      <= w_re;
            r_iss_cl3  <= w_cl3;
            r_p1_v     <= !w_flush && r_iss && r_iss_cl3;
            r_p1_d     <= r_mem_q;
            r_dq_oe    <= !w_flush && (w_direct || r_p1_v);
            r_dq_out   <= w_direct ? r_mem_q : r_p1_d;
        end
    end

    assign sdram_dq_out = r_dq_out;
    assign sdram_dq_oe  = r_dq_oe;
    assign mode_ok      = r_mode_ok;
    assign cas_lat      = r_cl;
    assign refresh_cnt  = r_ref;
    assign proto_err    = r_perr;
    assign err_code     = r_ecode;
endmodule

// File: tb/tb_sdram_dev_responder.sv
// tb_sdram_dev_responder: directed vector table plus hand-written burst sequences for the SDRAM responder.
module tb_sdram_dev_responder;
    localparam int C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
    localparam int C_PRE = 4'b0010, C_AREF = 4'b0001, C_LMR = 4'b0000, C_BT = 4'b0110;
    localparam int DA = 16'hA0A0, DB = 16'hB1B1, DC = 16'hC2C2, DD = 16'hD3D3;
    localparam int DE = 16'hE4E4, DF = 16'hF5F5, DG = 16'h1234, DH = 16'h5678;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cmd = 4'b0111;
    logic [1:0]  ba = '0;
    logic [12:0] addr = '0;
    logic [15:0] dq_in = '0;
    logic [15:0] dq_out;
    logic        dq_oe, mode_ok, perr;
    logic [2:0]  cas_lat, err_code;
    logic [15:0] refresh_cnt;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic [15:0] dq;
        logic        oe;
        logic [15:0] edq;
        logic        perr;
        logic [2:0]  code;
        logic        mode;
        logic [2:0]  cl;
        logic [15:0] rf;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    sdram_dev_responder dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .sdram_cmd(cmd), .sdram_ba(ba), .sdram_addr(addr),
        .sdram_dq_in(dq_in), .sdram_dq_out(dq_out), .sdram_dq_oe(dq_oe), .mode_ok(mode_ok),
        .cas_lat(cas_lat), .refresh_cnt(refresh_cnt), .proto_err(perr), .err_code(err_code)
    );

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int c, input int b, input int a, input int d);
        cmd = 4'(c);
        ba = 2'(b);
        addr = 13'(a);
        dq_in = 16'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input int c, b, a, d, oe, edq, pe, code, mode, cl, rf);
        vec_t v;
        v.cmd = 4'(c); v.ba = 2'(b); v.addr = 13'(a); v.dq = 16'(d); v.oe = 1'(oe);
        v.edq = 16'(edq); v.perr = 1'(pe); v.code = 3'(code); v.mode = 1'(mode);
        v.cl = 3'(cl); v.rf = 16'(rf);
        tv.push_back(v);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step(tv[i].cmd, tv[i].ba, tv[i].addr, tv[i].dq);
            chk($sformatf("v%0d_oe", i), dq_oe, tv[i].oe);
            if (tv[i].oe) chk($sformatf("v%0d_dq", i), dq_out, tv[i].edq);
            chk($sformatf("v%0d_perr", i), perr, tv[i].perr);
            chk($sformatf("v%0d_code", i), err_code, tv[i].code);
            chk($sformatf("v%0d_mode", i), mode_ok, tv[i].mode);
            chk($sformatf("v%0d_cl", i), cas_lat, tv[i].cl);
            chk($sformatf("v%0d_ref", i), refresh_cnt, tv[i].rf);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int hi_cnt;
        int i;
        addv(C_PRE, 0, 'h400, 0, 0, 0, 0, 0, 0, 3, 0);
        addv(C_AREF, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
        addv(C_AREF, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2);
        addv(C_LMR, 0, 'h037, 0, 0, 0, 0, 0, 1, 3, 2);
        addv(C_PRE, 0, 'h400, 0, 0, 0, 0, 0, 1, 3, 2);
        addv(C_LMR, 0, 'h032, 0, 0, 0, 0, 0, 1, 3, 2);
        addv(C_ACT, 1, 5, 0, 0, 0, 0, 0, 1, 3, 2);
        addv(C_WR, 1, 6, DA, 0, 0, 0, 0, 1, 3, 2);
        addv(C_NOP, 0, 0, DB, 0, 0, 0, 0, 1, 3, 2);
        addv(C_NOP, 0, 0, DC, 0, 0, 0, 0, 1, 3, 2);
        addv(C_NOP, 0, 0, DD, 0, 0, 0, 0, 1, 3, 2);
        addv(C_RD, 1, 4, 0, 0, 0, 0, 0, 1, 3, 2);
        addv(C_NOP, 0, 0, 0, 0, 0, 0, 0, 1, 3, 2);
        addv(C_NOP, 0, 0, 0, 1, DC, 0, 0, 1, 3, 2);
        addv(C_NOP, 0, 0, 0, 1, DD, 0, 0, 1, 3, 2);
        addv(C_NOP, 0, 0, 0, 1, DA, 0, 0, 1, 3, 2);
        addv(C_NOP, 0, 0, 0, 1, DB, 0, 0, 1, 3, 2);
        addv(C_NOP, 0, 0, 0, 0, 0, 0, 0, 1, 3, 2);
        addv(C_RD, 2, 0, 0, 0, 0, 1, 4, 1, 3, 2);
        addv(C_NOP, 0, 0, 0, 0, 0, 0, 4, 1, 3, 2);
        addv(C_ACT, 0, 0, 0, 0, 0, 0, 4, 1, 3, 2);
        addv(C_AREF, 0, 0, 0, 0, 0, 1, 3, 1, 3, 2);
        addv(C_ACT, 0, 0, 0, 0, 0, 1, 2, 1, 3, 2);
        addv(C_LMR, 0, 'h032, 0, 0, 0, 1, 5, 1, 3, 2);
        addv(C_NOP, 0, 0, 0, 0, 0, 0, 5, 1, 3, 2);
        addv(C_PRE, 1, 0, 0, 0, 0, 0, 5, 1, 3, 2);
        addv(C_WR, 1, 0, 0, 0, 0, 1, 4, 1, 3, 2);
        addv(C_PRE, 0, 'h400, 0, 0, 0, 0, 4, 1, 3, 2);
        addv(C_AREF, 0, 0, 0, 0, 0, 0, 4, 1, 3, 3);
        addv(C_LMR, 0, 'h052, 0, 0, 0, 1, 6, 1, 3, 3);
        addv(C_LMR, 0, 'h021, 0, 0, 0, 0, 6, 1, 2, 3);
        addv(C_ACT, 3, 0, 0, 0, 0, 0, 6, 1, 2, 3);
        addv(C_WR, 3, 511, DE, 0, 0, 0, 6, 1, 2, 3);
        addv(C_NOP, 0, 0, DF, 0, 0, 0, 6, 1, 2, 3);
        addv(C_RD, 3, 510, 0, 0, 0, 0, 6, 1, 2, 3);
        addv(C_NOP, 0, 0, 0, 1, DF, 0, 6, 1, 2, 3);
        addv(C_NOP, 0, 0, 0, 1, DE, 0, 6, 1, 2, 3);
        addv(C_NOP, 0, 0, 0, 0, 0, 0, 6, 1, 2, 3);
        addv(C_RD, 3, 510, 0, 0, 0, 0, 6, 1, 2, 3);
        addv(C_WR, 3, 0, DG, 0, 0, 0, 6, 1, 2, 3);
        addv(C_NOP, 0, 0, DH, 0, 0, 0, 6, 1, 2, 3);
        addv(C_NOP, 0, 0, 0, 0, 0, 0, 6, 1, 2, 3);
        addv(C_PRE, 0, 'h400, 0, 0, 0, 0, 6, 1, 2, 3);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_oe", dq_oe, 0);
        chk("rst_dq", dq_out, 0);
        chk("rst_mode", mode_ok, 0);
        chk("rst_cl", cas_lat, 3);
        chk("rst_ref", refresh_cnt, 0);
        chk("rst_perr", perr, 0);
        chk("rst_code", err_code, 0);
        rst_n = 1'b1;
        run_vecs(0, 3);

        step(C_ACT, 0, 0, 0);
        step(C_WR, 0, 0, 0);
        chk("wr_oe", dq_oe, 0);
        for (int k = 1; k < 256; k++) step(C_NOP, 0, 0, k);
        step(C_BT, 0, 0, 0);
        step(C_RD, 0, 0, 0);
        hi_cnt = 0;
        for (int j = 1; j <= 260; j++) begin
            step(j == 256 ? C_BT : C_NOP, 0, 0, 0);
            chk($sformatf("page_oe_%0d", j), dq_oe, (j >= 2 && j <= 257) ? 1 : 0);
            if (j >= 2 && j <= 257) chk($sformatf("page_dq_%0d", j), dq_out, j - 2);
            hi_cnt += int'(dq_oe);
        end
        chk("page_oe_cycles", hi_cnt, 256);

        run_vecs(4, tv.size() - 1);

        step(C_LMR, 0, 'h037, 0);
        chk("lmr_page_cl", cas_lat, 3);
        chk("lmr_page_perr", perr, 0);
        step(C_ACT, 0, 0, 0);
        step(C_RD, 0, 0, 0);
        for (int j = 1; j <= 22; j++) begin
            step(j == 10 ? C_RD : C_NOP, 0, j == 10 ? 100 : 0, 0);
            i = j - 2;
            chk($sformatf("rerd_oe_%0d", j), dq_oe, j >= 2 ? 1 : 0);
            if (j >= 2) chk($sformatf("rerd_dq_%0d", j), dq_out, i < 10 ? i : 90 + i);
        end

        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_oe", dq_oe, 0);
        chk("arst_mode", mode_ok, 0);
        chk("arst_cl", cas_lat, 3);
        chk("arst_ref", refresh_cnt, 0);
        chk("arst_code", err_code, 0);
        @(posedge clk);
        #1;
        chk("arst_oe_hold", dq_oe, 0);
        #2;
        rst_n = 1'b1;
        step(C_NOP, 0, 0, 0);
        step(C_RD, 0, 0, 0);
        chk("post_rd_perr", perr, 1);
        chk("post_rd_code", err_code, 1);
        chk("post_rd_oe", dq_oe, 0);
        step(C_NOP, 0, 0, 0);
        chk("post_nop_perr", perr, 0);
        step(C_NOP, 0, 0, 0);
        chk("post_nop_oe", dq_oe, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
